// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display.
// Ports: CLK, RST_N (sync, active-low); DATA/DP/EN_MASK + LOAD fill a shadow
//   register (PEND while uncommitted); SEG/AN are active-low display drives;
//   FRAME_TICK pulses for one cycle after each frame boundary.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DATA,
    input  logic [7:0]  DP,
    input  logic [7:0]  EN_MASK,
    input  logic        LOAD,
    output logic        PEND,
    output logic [7:0]  SEG,
    output logic [7:0]  AN,
    output logic        FRAME_TICK
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    typedef enum logic {
        BLANK,
        SHOW
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;

    logic [31:0]   sh_data;
    logic [7:0]    sh_dp, sh_en;
    logic [31:0]   act_data, act_data_d;
    logic [7:0]    act_dp, act_dp_d;
    logic [7:0]    act_en, act_en_d;
    logic          pend_d;
    logic          frame_edge;
    logic [3:0]    nib;
    logic [7:0]    seg_d, an_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        frame_edge = (idx_q == 3'd7) && (cnt_q == CNT_LAST);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Commit uses the shadow as it stood before this edge, so a LOAD
        // landing on the boundary is held over to the next frame.
        act_data_d = act_data;
        act_dp_d   = act_dp;
        act_en_d   = act_en;
        if (frame_edge && PEND) begin
            act_data_d = sh_data;
            act_dp_d   = sh_dp;
            act_en_d   = sh_en;
        end

        pend_d = PEND;
        if (frame_edge) pend_d = 1'b0;
        if (LOAD)       pend_d = 1'b1;

        state_d = state_q;
        case (state_q)
            BLANK: if (cnt_d >= BLANK_END) state_d = SHOW;
            SHOW:  if (cnt_q == CNT_LAST)  state_d = BLANK;
            default: state_d = BLANK;
        endcase

        // Outputs are registered from post-edge counters so they line up
        // with the slot they belong to.
        nib   = act_data_d[{idx_d, 2'b00} +: 4];
        seg_d = 8'hFF;
        an_d  = 8'hFF;
        if (state_d == SHOW && act_en_d[idx_d]) begin
            an_d  = ~(8'd1 << idx_d);
            seg_d = {~act_dp_d[idx_d], hex7(nib)};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_data    <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            act_data   <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            PEND       <= 1'b0;
            SEG        <= 8'hFF;
            AN         <= 8'hFF;
            FRAME_TICK <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_data   <= act_data_d;
            act_dp     <= act_dp_d;
            act_en     <= act_en_d;
            PEND       <= pend_d;
            SEG        <= seg_d;
            AN         <= an_d;
            FRAME_TICK <= frame_edge;
            if (LOAD) begin
                sh_data <= DATA;
                sh_dp   <= DP;
                sh_en   <= EN_MASK;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=10, BLANK_CYC=2.
// A position-based reference model queues expected outputs; a monitor checks.
module tb_seg7_scan_ctrl;

    localparam int SD  = 10;
    localparam int BC  = 2;
    localparam int FRM = 8 * SD;

    localparam bit [7:0] HEX [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [7:0] seg;
        logic [7:0] an;
        logic       pend;
        logic       tick;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] DATA;
    logic [7:0]  DP;
    logic [7:0]  EN_MASK;
    logic        LOAD;
    logic        PEND;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        FRAME_TICK;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    int          m_pos = 0;
    logic [31:0] m_act_d = '0, m_sh_d = '0;
    logic [7:0]  m_act_p = '0, m_sh_p = '0;
    logic [7:0]  m_act_e = '0, m_sh_e = '0;
    logic        m_pend = 1'b0;

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .CLK(CLK), .RST_N(RST_N), .DATA(DATA), .DP(DP),
        .EN_MASK(EN_MASK), .LOAD(LOAD), .PEND(PEND), .SEG(SEG),
        .AN(AN), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    // Reference model: position since reset gives slot and digit directly.
    always @(posedge CLK) begin
        exp_t e;
        int   c;
        int   d;
        logic [31:0] tmp;
        if (!RST_N) begin
            m_pos = 0;
            m_act_d = '0; m_act_p = '0; m_act_e = '0;
            m_sh_d = '0;  m_sh_p = '0;  m_sh_e = '0;
            m_pend = 1'b0;
            e = '{seg: 8'hFF, an: 8'hFF, pend: 1'b0, tick: 1'b0};
        end else begin
            m_pos = m_pos + 1;
            e.tick = (m_pos % FRM) == 0;
            if (e.tick && m_pend) begin
                m_act_d = m_sh_d; m_act_p = m_sh_p; m_act_e = m_sh_e;
                m_pend = 1'b0;
            end
            if (LOAD) begin
                m_sh_d = DATA; m_sh_p = DP; m_sh_e = EN_MASK;
                m_pend = 1'b1;
            end
            c = m_pos % SD;
            d = (m_pos / SD) % 8;
            e.pend = m_pend;
            e.seg = 8'hFF;
            e.an = 8'hFF;
            if (c >= BC && m_act_e[d]) begin
                tmp = m_act_d >> (4 * d);
                e.an = 8'hFF;
                e.an[d] = 1'b0;
                e.seg = HEX[tmp[3:0]];
                e.seg[7] = ~m_act_p[d];
            end
        end
        q.push_back(e);
    end

    always @(negedge CLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (SEG !== e.seg || AN !== e.an || PEND !== e.pend
                || FRAME_TICK !== e.tick) begin
                errors++;
                $display("FAIL out t=%0t got seg=%h an=%h pend=%b tick=%b exp seg=%h an=%h pend=%b tick=%b",
                         $time, SEG, AN, PEND, FRAME_TICK,
                         e.seg, e.an, e.pend, e.tick);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] p,
                        input logic [7:0] e);
        DATA = d; DP = p; EN_MASK = e; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic wait_pos(input int r, input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 3 * FRM; i++) begin
            if (m_pos % FRM == r) begin
                ok = 1;
                break;
            end
            @(negedge CLK);
        end
        if (ok == 0) begin
            checks++;
            errors++;
            $display("FAIL %s alignment timeout got pos=%0d want %0d", nm, m_pos, r);
        end
    endtask

    initial begin
        RST_N = 1'b0; LOAD = 1'b0; DATA = '0; DP = '0; EN_MASK = '0;
        idle(2);
        RST_N = 1'b1;
        idle(100);
        load(32'h76543210, 8'h00, 8'hFF);
        idle(170);
        load(32'hFEDCBA98, 8'h02, 8'hFF);
        idle(170);
        load(32'h76543210, 8'h00, 8'h0F);
        idle(170);
        wait_pos(5, "two_loads");
        load(32'h11111111, 8'h00, 8'hFF);
        idle(20);
        load(32'hAAAAAAAA, 8'h00, 8'hFF);
        idle(90);
        wait_pos(FRM - 1, "boundary_load");
        load(32'h22222222, 8'h00, 8'hFF);
        idle(200);
        wait_pos(35, "mid_reset");
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        idle(100);
        load(32'h00000000, 8'h00, 8'hFF);
        idle(100);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                RST_N = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
            end
            load($urandom, 8'($urandom), 8'($urandom));
            idle($urandom_range(0, 150));
        end
        idle(200);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
